// File: rtl/dsram_pkg.sv
// Shared types, constants and helpers for the data-side SRAM slave.
package dsram_pkg;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  wen_t;

    localparam logic [15:0] MMIO_BASE_DEF = 16'h1FAF;
    localparam logic [13:0] COUNT_OFFSET  = 14'h0;

    // Which source drives rdata for the request accepted at the last edge.
    typedef enum logic [1:0] {
        RSRC_ZERO  = 2'd0,
        RSRC_RAM   = 2'd1,
        RSRC_COUNT = 2'd2
    } rsrc_e;

    // Replace the lanes of old_w selected by wen with the matching lanes of new_w.
    function automatic word_t byte_merge(word_t old_w, word_t new_w, wen_t wen);
        word_t r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) begin
                r[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/data_sram_slave_if.sv
// Data-side SRAM request bus between the MEM stage (master) and the memory (slave).
interface data_sram_slave_if;
    import dsram_pkg::*;

    logic  data_sram_en;
    wen_t  data_sram_wen;
    logic [31:0] data_sram_addr;
    word_t data_sram_wdata;
    word_t data_sram_rdata;

    modport master (
        output data_sram_en,
        output data_sram_wen,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_rdata
    );

    modport slave (
        input  data_sram_en,
        input  data_sram_wen,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_rdata
    );
endinterface

// File: rtl/dsram_array.sv
// Byte-enabled, read-first synchronous RAM. Contents are never reset.
// Read and write addresses are separate so a buffered write can commit in
// the same cycle as an unrelated read; when both come from one request the
// two addresses are identical and the array behaves as a single port.
module dsram_array
    import dsram_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_idx,
    output word_t             rd_data,
    input  logic              we,
    input  wen_t              wr_be,
    input  logic [ADDR_W-1:0] wr_idx,
    input  word_t             wr_data
);

    word_t mem [2**ADDR_W];
    word_t rd_data_q;

    // Lane-masked write and registered read; NBA ordering gives read-first.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_idx];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/data_sram_slave.sv
// Data-side SRAM responder: RAM array, free-running COUNT in an MMIO window,
// one-cycle registered read data.
// Optional build macro DSRAM_WBUF_EN: RAM writes go through a one-entry
// pending register and commit one edge later, with read-side byte merge.
module data_sram_slave
    import dsram_pkg::*;
#(
    parameter int          ADDR_W    = 14,
    parameter logic [15:0] MMIO_BASE = MMIO_BASE_DEF
) (
    input  logic               clk,
    input  logic               rst,
    data_sram_slave_if.slave   bus
);

    logic              mmio_win;
    logic              cnt_hit;
    logic              ram_sel;
    logic              req_wr;
    logic [ADDR_W-1:0] idx;
    word_t             count_inc;
    word_t             arr_rd;
    word_t             rdata;

    word_t count_q,  count_d;
    word_t cnt_rd_q, cnt_rd_d;
    rsrc_e rsrc_q,   rsrc_d;

    logic              arr_we;
    wen_t              arr_be;
    logic [ADDR_W-1:0] arr_widx;
    word_t             arr_wdata;

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^bus.data_sram_addr[1:0];

    assign mmio_win  = (bus.data_sram_addr[31:16] == MMIO_BASE);
    assign cnt_hit   = mmio_win && (bus.data_sram_addr[15:2] == COUNT_OFFSET);
    assign ram_sel   = !mmio_win;
    assign req_wr    = |bus.data_sram_wen;
    assign idx       = bus.data_sram_addr[ADDR_W+1:2];
    assign count_inc = count_q + 32'd1;

    // COUNT update and read-source selection; a COUNT read reports the value
    // the counter takes at the request edge, ignoring a same-cycle write.
    always_comb begin
        count_d  = count_inc;
        rsrc_d   = rsrc_q;
        cnt_rd_d = cnt_rd_q;
        if (bus.data_sram_en) begin
            if (ram_sel) begin
                rsrc_d = RSRC_RAM;
            end else if (cnt_hit) begin
                rsrc_d = RSRC_COUNT;
            end else begin
                rsrc_d = RSRC_ZERO;
            end
            if (cnt_hit) begin
                cnt_rd_d = count_inc;
                if (req_wr) begin
                    count_d = byte_merge(count_inc, bus.data_sram_wdata, bus.data_sram_wen);
                end
            end
        end
    end

    // COUNT and read-source registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            cnt_rd_q <= '0;
            rsrc_q   <= RSRC_ZERO;
        end else begin
            count_q  <= count_d;
            cnt_rd_q <= cnt_rd_d;
            rsrc_q   <= rsrc_d;
        end
    end

`ifdef DSRAM_WBUF_EN
    logic              pend_vld_q,  pend_vld_d;
    logic [ADDR_W-1:0] pend_idx_q,  pend_idx_d;
    wen_t              pend_wen_q,  pend_wen_d;
    word_t             pend_data_q, pend_data_d;
    wen_t              mrg_wen_q,   mrg_wen_d;
    word_t             mrg_data_q,  mrg_data_d;

    // Capture a new RAM write; snapshot any pending bytes a RAM read must see.
    always_comb begin
        pend_vld_d  = 1'b0;
        pend_idx_d  = pend_idx_q;
        pend_wen_d  = pend_wen_q;
        pend_data_d = pend_data_q;
        mrg_wen_d   = mrg_wen_q;
        mrg_data_d  = mrg_data_q;
        if (bus.data_sram_en && ram_sel) begin
            if (pend_vld_q && (pend_idx_q == idx)) begin
                mrg_wen_d = pend_wen_q;
            end else begin
                mrg_wen_d = '0;
            end
            mrg_data_d = pend_data_q;
            if (req_wr) begin
                pend_vld_d  = 1'b1;
                pend_idx_d  = idx;
                pend_wen_d  = bus.data_sram_wen;
                pend_data_d = bus.data_sram_wdata;
            end
        end
    end

    // Pending write and merge registers; reset drops an uncommitted write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_vld_q  <= 1'b0;
            pend_idx_q  <= '0;
            pend_wen_q  <= '0;
            pend_data_q <= '0;
            mrg_wen_q   <= '0;
            mrg_data_q  <= '0;
        end else begin
            pend_vld_q  <= pend_vld_d;
            pend_idx_q  <= pend_idx_d;
            pend_wen_q  <= pend_wen_d;
            pend_data_q <= pend_data_d;
            mrg_wen_q   <= mrg_wen_d;
            mrg_data_q  <= mrg_data_d;
        end
    end

    assign arr_we    = pend_vld_q;
    assign arr_be    = pend_wen_q;
    assign arr_widx  = pend_idx_q;
    assign arr_wdata = pend_data_q;
`else
    assign arr_we    = bus.data_sram_en && ram_sel && req_wr;
    assign arr_be    = bus.data_sram_wen;
    assign arr_widx  = idx;
    assign arr_wdata = bus.data_sram_wdata;
`endif

    dsram_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .rd_en   (bus.data_sram_en && ram_sel),
        .rd_idx  (idx),
        .rd_data (arr_rd),
        .we      (arr_we),
        .wr_be   (arr_be),
        .wr_idx  (arr_widx),
        .wr_data (arr_wdata)
    );

    // Output select; every input to this mux is a register.
    always_comb begin
        rdata = '0;
        case (rsrc_q)
`ifdef DSRAM_WBUF_EN
            RSRC_RAM:   rdata = byte_merge(arr_rd, mrg_data_q, mrg_wen_q);
`else
            RSRC_RAM:   rdata = arr_rd;
`endif
            RSRC_COUNT: rdata = cnt_rd_q;
            default:    rdata = '0;
        endcase
    end

    assign bus.data_sram_rdata = rdata;

endmodule

// File: tb/tb_data_sram_slave.sv
// Self-checking bench for data_sram_slave: directed requests push expected
// rdata into a queue; a monitor compares one cycle later at the falling edge.
module tb_data_sram_slave;

    logic clk;
    logic rst;
    logic cur_chk;
    int   total;
    int   bad;

    logic [31:0] exp_q  [$];
    string       name_q [$];

    data_sram_slave_if bus_if ();

    data_sram_slave dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] CNT_ADDR = 32'h1FAF_0000;

    task automatic req(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic chk, input logic [31:0] exp,
                       input string nm);
        bus_if.data_sram_en    = en;
        bus_if.data_sram_wen   = wen;
        bus_if.data_sram_addr  = addr;
        bus_if.data_sram_wdata = wdata;
        cur_chk = chk;
        if (chk) begin
            exp_q.push_back(exp);
            name_q.push_back(nm);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string nm);
        req(1'b1, 4'h0, addr, 32'h0, 1'b1, exp, nm);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] d);
        req(1'b1, wen, addr, d, 1'b0, 32'h0, "");
    endtask

    task automatic wrc(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] d,
                       input logic [31:0] exp, input string nm);
        req(1'b1, wen, addr, d, 1'b1, exp, nm);
    endtask

    task automatic idle(input logic [31:0] exp, input string nm);
        req(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, exp, nm);
    endtask

    // Monitor: for each edge with a checked request, compare at the next falling edge.
    initial begin
        logic        p;
        logic [31:0] e;
        string       n;
        forever begin
            @(posedge clk);
            p = cur_chk;
            @(negedge clk);
            if (p) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL scoreboard_empty: got %h, required an expected entry", bus_if.data_sram_rdata);
                end else begin
                    e = exp_q.pop_front();
                    n = name_q.pop_front();
                    if (bus_if.data_sram_rdata !== e) begin
                        bad++;
                        $display("FAIL %s: got %h, required %h", n, bus_if.data_sram_rdata, e);
                    end
                end
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        cur_chk = 1'b0;
        rst = 1'b1;
        bus_if.data_sram_en    = 1'b0;
        bus_if.data_sram_wen   = 4'h0;
        bus_if.data_sram_addr  = 32'h0;
        bus_if.data_sram_wdata = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus_if.data_sram_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_rdata: got %h, required 00000000", bus_if.data_sram_rdata);
        end
        rst = 1'b0;

        // COUNT sampled at edges 10 and 13 after release.
        for (int i = 1; i <= 9; i++) idle(32'h0, "hold_zero");
        rd(CNT_ADDR, 32'd10, "count_edge10");
        idle(32'd10, "hold_count");
        idle(32'd10, "hold_count");
        rd(CNT_ADDR, 32'd13, "count_edge13");

        // Full write then read; aliasing of upper bits and byte offset.
        wr(32'h0000_0010, 4'hF, 32'hDEAD_BEEF);
        rd(32'h0000_0010, 32'hDEAD_BEEF, "rd_full");
        rd(32'h0001_0013, 32'hDEAD_BEEF, "rd_alias");

        // Partial write, back-to-back.
        wr(32'h0000_0020, 4'hF, 32'h1122_3344);
        wrc(32'h0000_0020, 4'b0101, 32'hAABB_CCDD, 32'h1122_3344, "wr_ret_old");
        rd(32'h0000_0020, 32'h11BB_33DD, "rd_partial");

        // Read-first on a write to the same word.
        wr(32'h0000_0030, 4'hF, 32'h0);
        wrc(32'h0000_0030, 4'hF, 32'h5, 32'h0, "rw_same_old");
        rd(32'h0000_0030, 32'h5, "rw_same_new");

        // COUNT wrap after a full write.
        wr(CNT_ADDR, 4'hF, 32'hFFFF_FFFE);
        rd(CNT_ADDR, 32'hFFFF_FFFF, "count_pre_wrap");
        rd(CNT_ADDR, 32'h0, "count_wrap");

        // COUNT partial-lane write: other lanes take count+1.
        wr(CNT_ADDR, 4'hF, 32'hFFFF_FF00);
        wrc(CNT_ADDR, 4'b0001, 32'h0000_0055, 32'hFFFF_FF01, "count_wr_ret");
        rd(CNT_ADDR, 32'hFFFF_FF56, "count_lane");

        // Rest of the MMIO window reads zero and ignores writes.
        rd(32'h0000_0030, 32'h5, "rd_before_mmio");
        wrc(32'h1FAF_0004, 4'hF, 32'h0000_1234, 32'h0, "mmio_wr_ret");
        rd(32'h1FAF_0004, 32'h0, "mmio_other");
        rd(32'h0000_0030, 32'h5, "ram_untouched");

        // Reset directly after a write to 0x40.
        wr(32'h0000_0040, 4'hF, 32'h0BAD_F00D);
        rd(32'h0000_0040, 32'h0BAD_F00D, "rd_0x40_old");
        wr(32'h0000_0040, 4'hF, 32'h1234_5678);
        rst = 1'b1;
        cur_chk = 1'b0;
        bus_if.data_sram_en  = 1'b0;
        bus_if.data_sram_wen = 4'h0;
        #1;
        total++;
        if (bus_if.data_sram_rdata !== 32'h0) begin
            bad++;
            $display("FAIL rst_mid_rdata: got %h, required 00000000", bus_if.data_sram_rdata);
        end
        total++;
        if (dut.count_q !== 32'h0) begin
            bad++;
            $display("FAIL rst_mid_count: got %h, required 00000000", dut.count_q);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
`ifdef DSRAM_WBUF_EN
        rd(32'h0000_0040, 32'h0BAD_F00D, "rst_drops_pending");
`else
        rd(32'h0000_0040, 32'h1234_5678, "rst_keeps_direct");
`endif
        rd(CNT_ADDR, 32'd2, "count_after_rst");

        // Drain with a bounded wait.
        cur_chk = 1'b0;
        bus_if.data_sram_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d entries left, required 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
